// File: rtl/idle_deleter.sv
// TX clock-compensation stage ahead of the 66b block FIFO.
// Drops owed idle blocks so the AM inserter gets room each period.
module idle_deleter #(
  parameter int NB_DATA   = 66,
  parameter int PERIOD    = 16384,
  parameter int NB_PERIOD = 14,
  parameter int N_DELETE  = 20,
  parameter int NB_CREDIT = 6
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic [NB_DATA-1:0]   i_data,
  output logic [NB_DATA-1:0]   o_data,
  output logic                 o_write_enb,
  output logic [NB_CREDIT-1:0] o_credit,
  output logic                 o_credit_ovf
);

  localparam int CW = NB_CREDIT + 1;
  localparam logic [NB_PERIOD-1:0] P_LAST = NB_PERIOD'(PERIOD - 1);
  localparam logic [CW-1:0] C_ADD = CW'(N_DELETE);
  localparam logic [CW-1:0] C_MAX = CW'(2 * N_DELETE);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic [NB_PERIOD-1:0] period_q, period_d;
  logic [NB_CREDIT-1:0] credit_q, credit_d;
  logic                 ovf_q, ovf_d;
  logic [NB_DATA-1:0]   data_q, data_d;
  logic                 we_q, we_d;

  logic          fire;
  logic          is_idle;
  logic          del;
  logic          tick;
  logic [CW-1:0] sum;

  assign fire    = i_enable & i_valid;
  assign is_idle = (i_data[65:64] == 2'b10) &&
                   (i_data[63:56] == 8'h1E) &&
                   (i_data[55:0] == 56'd0);
  assign del     = fire & is_idle & (credit_q != '0);
  assign tick    = fire & (period_q == P_LAST);

  // Tick credit and deletion debit resolve in one step.
  assign sum = {1'b0, credit_q}
             + (tick ? C_ADD : '0)
             - (del ? C_ONE : '0);

  always_comb begin
    period_d = period_q;
    if (fire) begin
      period_d = tick ? '0 : period_q + 1'b1;
    end
  end

  always_comb begin
    credit_d = sum[NB_CREDIT-1:0];
    ovf_d    = ovf_q;
    if (sum > C_MAX) begin
      credit_d = C_MAX[NB_CREDIT-1:0];
      ovf_d    = 1'b1;
    end
  end

  always_comb begin
    we_d   = fire & ~del;
    data_d = we_d ? i_data : data_q;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      period_q <= '0;
      credit_q <= '0;
      ovf_q    <= 1'b0;
      data_q   <= '0;
      we_q     <= 1'b0;
    end else begin
      period_q <= period_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
      we_q     <= we_d;
    end
  end

  assign o_data       = data_q;
  assign o_write_enb  = we_q;
  assign o_credit     = credit_q;
  assign o_credit_ovf = ovf_q;

endmodule

// File: tb/tb_idle_deleter.sv
// Directed bench for idle_deleter with a block scoreboard.
// Small period/credit parameters exercise wrap and saturation.
module tb_idle_deleter;

  localparam int NB_DATA   = 66;
  localparam int PERIOD    = 8;
  localparam int NB_PERIOD = 3;
  localparam int N_DELETE  = 2;
  localparam int NB_CREDIT = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic                 vld;
  logic [NB_DATA-1:0]   din;
  logic [NB_DATA-1:0]   dout;
  logic                 we;
  logic [NB_CREDIT-1:0] credit;
  logic                 ovf;

  int checks   = 0;
  int failures = 0;

  logic [NB_DATA-1:0] sb[$];
  int   m_credit;
  int   m_period;
  logic m_ovf;

  localparam logic [65:0] IDLE = {2'b10, 8'h1E, 56'd0};

  always #5 clk = ~clk;

  idle_deleter #(
    .NB_DATA  (NB_DATA),
    .PERIOD   (PERIOD),
    .NB_PERIOD(NB_PERIOD),
    .N_DELETE (N_DELETE),
    .NB_CREDIT(NB_CREDIT)
  ) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_enable    (en),
    .i_valid     (vld),
    .i_data      (din),
    .o_data      (dout),
    .o_write_enb (we),
    .o_credit    (credit),
    .o_credit_ovf(ovf)
  );

  task automatic chk(input string tag, input logic [65:0] obs,
                     input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic idle_blk(input logic [65:0] d);
    return d[65:64] == 2'b10 && d[63:56] == 8'h1E && d[55:0] == 56'd0;
  endfunction

  function automatic logic [65:0] dblk(input int n);
    return {2'b01, 8'h78, 24'hA5A5A5, 32'(n)};
  endfunction

  // Drive one cycle, advance the model, then check after the edge.
  task automatic step(input logic e, input logic v, input logic [65:0] d);
    logic exp_we;
    logic drop;
    logic tk;
    int   nc;
    logic [65:0] exp_d;
    en  = e;
    vld = v;
    din = d;
    exp_we = 1'b0;
    if (e && v) begin
      drop = idle_blk(d) && (m_credit > 0);
      tk = (m_period == PERIOD - 1);
      m_period = tk ? 0 : m_period + 1;
      nc = m_credit + (tk ? N_DELETE : 0) - (drop ? 1 : 0);
      if (nc > 2 * N_DELETE) begin
        nc = 2 * N_DELETE;
        m_ovf = 1'b1;
      end
      m_credit = nc;
      exp_we = !drop;
      if (!drop) sb.push_back(d);
    end
    @(posedge clk);
    #1;
    chk("write_enb", 66'(we), 66'(exp_we));
    if (we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 66'(1), 66'(0));
      end else begin
        exp_d = sb.pop_front();
        chk("data", dout, exp_d);
      end
    end
    chk("credit", 66'(credit), 66'(m_credit));
    chk("ovf", 66'(ovf), 66'(m_ovf));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_data", dout, 66'd0);
    chk("rst_we", 66'(we), 66'd0);
    chk("rst_credit", 66'(credit), 66'd0);
    chk("rst_ovf", 66'(ovf), 66'd0);
    m_credit = 0;
    m_period = 0;
    m_ovf = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    en  = 1'b0;
    vld = 1'b0;
    din = '0;
    #3;
    do_reset();

    // Eight data blocks: credit arrives after the eighth.
    for (int i = 0; i < 7; i++) step(1, 1, dblk(i));
    chk("credit_pre_tick", 66'(credit), 66'd0);
    step(1, 1, dblk(7));
    chk("credit_tick1", 66'(credit), 66'd2);

    // Three idles: two dropped, third written.
    step(1, 1, IDLE);
    chk("idle1_we", 66'(we), 66'd0);
    chk("idle1_cr", 66'(credit), 66'd1);
    step(1, 1, IDLE);
    chk("idle2_cr", 66'(credit), 66'd0);
    step(1, 1, IDLE);
    chk("idle3_we", 66'(we), 66'd1);
    chk("idle3_cr", 66'(credit), 66'd0);

    // Reach counter 7 with credit 1, then idle on the wrap block.
    for (int i = 0; i < 5; i++) step(1, 1, dblk(100 + i));
    step(1, 1, IDLE);
    for (int i = 0; i < 6; i++) step(1, 1, dblk(200 + i));
    chk("wrap_pre_cr", 66'(credit), 66'd1);
    step(1, 1, IDLE);
    chk("wrap_we", 66'(we), 66'd0);
    chk("wrap_cr", 66'(credit), 66'd2);

    // Three data-only periods: saturation and sticky flag.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < PERIOD; i++) step(1, 1, dblk(300 + 8 * p + i));
      chk("sat_cr", 66'(credit), 66'd4);
    end
    chk("sat_ovf", 66'(ovf), 66'd1);
    step(1, 0, '0);
    chk("ovf_sticky", 66'(ovf), 66'd1);

    do_reset();
    chk("ovf_cleared", 66'(ovf), 66'd0);
    for (int i = 0; i < PERIOD; i++) step(1, 1, dblk(400 + i));
    chk("cr_reload", 66'(credit), 66'd2);

    // Near-idle blocks always pass.
    step(1, 1, {2'b10, 8'h1E, 56'h1E});
    chk("ctrl_we", 66'(we), 66'd1);
    chk("ctrl_cr", 66'(credit), 66'd2);
    step(1, 1, {2'b00, 8'h1E, 56'd0});
    step(1, 1, {2'b11, 8'h1E, 56'd0});
    chk("badhdr_cr", 66'(credit), 66'd2);

    // Bubbles and disabled cycles freeze state.
    step(1, 0, IDLE);
    chk("novalid_we", 66'(we), 66'd0);
    step(0, 1, IDLE);
    chk("disabled_we", 66'(we), 66'd0);
    chk("disabled_cr", 66'(credit), 66'd2);
    chk("disabled_data", dout, {2'b11, 8'h1E, 56'd0});

    // Credit 3 at counter 5, then async reset off-edge.
    for (int i = 0; i < 5; i++) step(1, 1, dblk(500 + i));
    step(1, 1, IDLE);
    for (int i = 0; i < 4; i++) step(1, 1, dblk(600 + i));
    chk("mid_cr", 66'(credit), 66'd3);
    #2;
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 1, dblk(700 + i));
    chk("post_rst_pre", 66'(credit), 66'd0);
    step(1, 1, dblk(707));
    chk("post_rst_tick", 66'(credit), 66'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idle_deleter.md
Name: idle_deleter

Overview:
- TX clock-compensation stage sitting directly upstream of the synchronous 66b-block FIFO; its outputs drive the FIFO write data and write enable.
- Removes N_DELETE idle blocks per alignment-marker period. This opens room so the downstream AM inserter can place its markers while the FIFO reads at a constant rate.
- Registered single-cycle datapath with a deletion-credit counter and a block-period counter.

Parameters:
- NB_DATA, 66: block width. Bits [65:64] are the sync header, [63:56] the block type, [55:0] eight 7-bit control characters.
- PERIOD, 16384: valid blocks per AM period.
- NB_PERIOD, 14: period counter width; must satisfy 2**NB_PERIOD >= PERIOD.
- N_DELETE, 20: idle blocks to delete per period.
- NB_CREDIT, 6: credit counter width; must satisfy 2**NB_CREDIT > 2*N_DELETE.

Ports:
- i_clock, in, 1: single clock.
- i_reset_n, in, 1: asynchronous active-low reset.
- i_enable, in, 1: clock enable; all state frozen when low.
- i_valid, in, 1: i_data carries a block this cycle.
- i_data, in, NB_DATA: input 66b block.
- o_data, out, NB_DATA: block to FIFO write port.
- o_write_enb, out, 1: FIFO write enable.
- o_credit, out, NB_CREDIT: idle deletions still owed.
- o_credit_ovf, out, 1: sticky flag; credit saturated.

Behaviour:
- Reset (async, i_reset_n=0):
  - o_data=0, o_write_enb=0, o_credit=0, o_credit_ovf=0.
  - Period counter = 0.
  - Release is synchronous to i_clock.
- Idle detection (combinational on i_data): is_idle = (i_data[65:64]==2'b10) && (i_data[63:56]==8'h1E) && (i_data[55:0]==0).
- Enable gating: when i_enable=0, counters, credit and flag hold, and o_write_enb=0 next cycle; o_data holds.
- Per cycle with i_enable=1 and i_valid=1:
  - Deletion: if is_idle and credit>0, the block is dropped. o_write_enb=0 next cycle and the credit decrements by 1.
  - Otherwise, pass: o_data<=i_data and o_write_enb=1 next cycle. Latency is exactly 1 cycle.
  - The period counter increments. At PERIOD-1 it wraps to 0 and generates period_tick. Dropped blocks are counted too, because the counter measures input blocks.
- With i_valid=0 (and i_enable=1): o_write_enb=0 next cycle, counter and credit hold, o_data holds.
- Credit update on period_tick: credit_next = credit + N_DELETE − (1 if a deletion occurs this same cycle).
  - A simultaneous tick and deletion is evaluated in one step; the deleted block uses the credit available before the tick.
  - Saturation: if credit_next > 2*N_DELETE, credit = 2*N_DELETE and o_credit_ovf is set. The flag stays set until reset.
- Non-idle blocks are never dropped, whatever the credit. Data blocks, control blocks with any non-zero char, and bad sync headers (00/11) all pass unmodified.
- Credit underflow is impossible: deletion requires credit>0.
- Reset mid-stream: all state clears asynchronously and the block in flight is lost. The downstream FIFO is reset by the same reset tree.
- No backpressure: the FIFO is sized so the net input rate is ≤ the read rate, and overflow is the FIFO's concern.

Test Plan (PERIOD=8, NB_PERIOD=3, N_DELETE=2, NB_CREDIT=3 unless noted):
- Reset then 8 valid data blocks (header 01) → all 8 appear on o_data one cycle later with o_write_enb=1. o_credit goes 0→2 on the cycle after block 8.
- Credit=2, then stream idle, idle, idle (header 10, type 1E, chars 0) → first two dropped (o_write_enb=0), third written. o_credit goes 2→1→0→0.
- Idle presented exactly on the period-wrap block with credit=1 → block dropped and o_credit=2 (1+2−1).
- 3 periods of data blocks with no idles → o_credit 2→4→4; o_credit_ovf=1 after the 3rd tick and stays 1 until i_reset_n pulses low.
- Control block type 1E with one char =7'h1E, credit=2 → passed unmodified and credit unchanged. Also toggle i_valid=0 and i_enable=0 mid-period → counter and credit hold, o_write_enb=0.
- Assert i_reset_n=0 asynchronously mid-cycle with credit=3 and counter=5 → all outputs 0 immediately with no clock edge. After release, the first tick arrives after 8 more valid blocks.
